// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: EX forwarding selects,
// load-use bubbles, memory-wait freezes, redirect sequencing and saturating perf counters.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 32,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [4:0]             ex_rs1,
  input  logic [4:0]             ex_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_load,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_regwrite,
  input  logic [2:0]             mem_src,
  input  logic [4:0]             wb_rd,
  input  logic                   wb_regwrite,
  input  logic [2:0]             wb_src,
  input  logic                   redirect_req,
  input  logic                   imem_read,
  input  logic                   imem_resp,
  input  logic                   dmem_req,
  input  logic                   dmem_resp,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_ex,
  output logic                   stall_mem,
  output logic                   stall_wb,
  output logic                   bubble_ex,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   pc_load,
  output logic [1:0]             pcmux_sel,
  output logic [3:0]             fwd_a,
  output logic [3:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, DWAIT, IWAIT, IFLUSH} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_pend;
  logic                   w_pend_next;
  logic                   r_active;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;

  logic w_dmiss;
  logic w_redir;
  logic w_fout;
  logic w_load_use;

  // A load result sitting in EX/MEM is not yet available, so it falls back to the register file.
  function automatic logic [3:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] m_rd, input logic m_we, input logic [2:0] m_src,
    input logic [4:0] w_rd, input logic w_we, input logic [2:0] w_src
  );
    fwd_sel = 4'h0;
    if (rs != 5'd0) begin
      if (m_we && (m_rd == rs)) begin
        if (m_src <= 3'd3) fwd_sel = 4'h2 + {1'b0, m_src};
      end else if (w_we && (w_rd == rs) && (w_src <= 3'd4)) begin
        fwd_sel = 4'h6 + {1'b0, w_src};
      end
    end
  endfunction

  assign w_dmiss    = (dmem_req || (r_state == DWAIT)) && !dmem_resp;
  assign w_redir    = redirect_req || r_pend || (r_state == IFLUSH);
  assign w_fout     = imem_read && !imem_resp;
  assign w_load_use = ex_load && ex_regwrite && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    stall_wb     = 1'b0;
    bubble_ex    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    pc_load      = 1'b0;
    pcmux_sel    = 2'b00;
    fwd_a        = 4'h0;
    fwd_b        = 4'h0;
    w_state_next = r_state;
    w_pend_next  = r_pend;
    if (r_active) begin
      fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, mem_src, wb_rd, wb_regwrite, wb_src);
      fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, mem_src, wb_rd, wb_regwrite, wb_src);
      if (w_dmiss || (w_redir && w_fout)) begin
        // Full freeze: either data memory is busy or a redirect waits for the stale fetch.
        {stall_if, stall_id, stall_ex, stall_mem, stall_wb} = 5'b11111;
        w_state_next = w_dmiss ? DWAIT : IFLUSH;
        w_pend_next  = w_redir;
      end else if (w_redir) begin
        pc_load      = 1'b1;
        pcmux_sel    = 2'b01;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        w_state_next = RUN;
        w_pend_next  = 1'b0;
      end else if (w_fout || w_load_use) begin
        stall_if     = 1'b1;
        stall_id     = 1'b1;
        bubble_ex    = 1'b1;
        w_state_next = w_fout ? IWAIT : RUN;
      end else begin
        pc_load      = 1'b1;
        w_state_next = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_pend      <= 1'b0;
      r_active    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_active <= 1'b1;
      r_state  <= w_state_next;
      r_pend   <= w_pend_next;
      if (stall_if && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_id_ex && (r_flush_cnt != {FLUSH_CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int SW = 8;
  localparam int FW = 4;
  localparam int SMAX = (1 << SW) - 1;
  localparam int FMAX = (1 << FW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_load, mem_regwrite, wb_regwrite;
  logic [2:0] mem_src, wb_src;
  logic redirect_req, imem_read, imem_resp, dmem_req, dmem_resp;
  logic stall_if, stall_id, stall_ex, stall_mem, stall_wb, bubble_ex;
  logic flush_if_id, flush_id_ex, pc_load;
  logic [1:0] pcmux_sel;
  logic [3:0] fwd_a, fwd_b;
  logic [SW-1:0] stall_cycles;
  logic [FW-1:0] flush_count;

  hazard_ctrl #(.STALL_CNT_W(SW), .FLUSH_CNT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_load(ex_load),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_src(mem_src),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_src(wb_src),
    .redirect_req(redirect_req), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .stall_wb(stall_wb), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .pc_load(pc_load), .pcmux_sel(pcmux_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit m_active = 1'b0;
  bit m_pend = 1'b0;
  bit p_pend_n = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  logic [10:0] e_ctl;
  logic [3:0] e_fa, e_fb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Newest producer holding the register wins; an in-flight load in EX/MEM cannot be forwarded.
  function automatic logic [3:0] ref_fwd(input logic [4:0] rs);
    logic [4:0] rd [2];
    logic       we [2];
    logic [2:0] src [2];
    rd[0] = mem_rd; we[0] = mem_regwrite; src[0] = mem_src;
    rd[1] = wb_rd;  we[1] = wb_regwrite;  src[1] = wb_src;
    for (int k = 0; k < 2; k++) begin
      if (rs != 0 && we[k] && rd[k] == rs) begin
        if (k == 0) return (src[k] == 3'd4) ? 4'h0 : 4'(2 + int'(src[k]));
        return 4'(6 + int'(src[k]));
      end
    end
    return 4'h0;
  endfunction

  function automatic logic [10:0] obs_ctl();
    return {stall_if, stall_id, stall_ex, stall_mem, stall_wb,
            bubble_ex, flush_if_id, flush_id_ex, pc_load, pcmux_sel};
  endfunction

  task automatic settle();
    bit redir, fout, lu, dmiss;
    #2;
    e_ctl = '0; e_fa = 4'h0; e_fb = 4'h0; p_pend_n = 1'b0;
    if (m_active) begin
      redir = redirect_req || m_pend;
      fout  = imem_read && !imem_resp;
      dmiss = dmem_req && !dmem_resp;
      lu    = ex_load && ex_regwrite && ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      p_pend_n = m_pend;
      if (dmiss) begin
        e_ctl = 11'b11111_000_0_00; p_pend_n = redir;
      end else if (redir && fout) begin
        e_ctl = 11'b11111_000_0_00; p_pend_n = 1'b1;
      end else if (redir) begin
        e_ctl = 11'b00000_011_1_01; p_pend_n = 1'b0;
      end else if (fout || lu) begin
        e_ctl = 11'b11000_100_0_00;
      end else begin
        e_ctl = 11'b00000_000_1_00;
      end
      e_fa = ref_fwd(ex_rs1);
      e_fb = ref_fwd(ex_rs2);
    end
    chk("ctl", 64'(obs_ctl()), 64'(e_ctl));
    chk("fwd_a", 64'(fwd_a), 64'(e_fa));
    chk("fwd_b", 64'(fwd_b), 64'(e_fb));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("flush_count", 64'(flush_count), 64'(m_flush));
  endtask

  task automatic adv();
    if (rst_n && m_active) begin
      if (e_ctl[10] && m_stall < SMAX) m_stall++;
      if (e_ctl[3] && m_flush < FMAX) m_flush++;
      m_pend = p_pend_n;
    end
    if (rst_n) m_active = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic clear_in();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_load, mem_regwrite, wb_regwrite} = '0;
    mem_src = 3'd0; wb_src = 3'd0;
    {redirect_req, imem_read, imem_resp, dmem_req, dmem_resp} = '0;
  endtask

  initial begin
    bit d_out, i_out;
    clear_in();
    // Reset: outputs forced low even with events requested
    #1;
    redirect_req = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1; mem_src = 3'd3; ex_rs1 = 5'd5;
    settle();
    $display("phase reset: outputs held at reset values");
    adv(); adv();
    clear_in();
    rst_n = 1'b1;
    settle();
    adv();

    // Forwarding
    mem_rd = 5'd5; wb_rd = 5'd5; ex_rs1 = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    mem_src = 3'd3; wb_src = 3'd4;
    settle(); chk("fwd_memsrc3", 64'(fwd_a), 64'h5); adv();
    mem_regwrite = 1'b0;
    settle(); chk("fwd_wbsrc4", 64'(fwd_a), 64'hA); adv();
    ex_rs1 = 5'd0;
    settle(); chk("fwd_x0", 64'(fwd_a), 64'h0); adv();
    $display("phase forwarding done");

    // Load-use
    clear_in();
    ex_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    settle(); chk("lu_bubble", 64'(bubble_ex), 64'h1); adv();
    clear_in();
    settle(); chk("lu_release", 64'(stall_if), 64'h0); chk("lu_count", 64'(stall_cycles), 64'd1); adv();
    $display("phase load-use done");

    // D-miss for 4 cycles
    dmem_req = 1'b1;
    repeat (4) begin settle(); chk("dmiss_stall_wb", 64'(stall_wb), 64'h1); adv(); end
    dmem_resp = 1'b1;
    settle(); chk("dmiss_release", 64'(stall_wb), 64'h0); chk("dmiss_count", 64'(stall_cycles), 64'd5); adv();
    clear_in();
    $display("phase dmiss done");

    // Redirect with fetch outstanding
    redirect_req = 1'b1; imem_read = 1'b1;
    repeat (3) begin settle(); chk("iflush_pcload", 64'(pc_load), 64'h0); adv(); end
    imem_resp = 1'b1;
    settle(); chk("iflush_end_flush", 64'(flush_if_id), 64'h1); chk("iflush_end_sel", 64'(pcmux_sel), 64'h1); adv();
    clear_in();
    settle(); chk("iflush_fcount", 64'(flush_count), 64'd1); adv();
    $display("phase redirect-with-fetch done");

    // Redirect together with load-use
    redirect_req = 1'b1;
    ex_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    settle(); chk("redir_lu_bubble", 64'(bubble_ex), 64'h0); adv();
    clear_in();

    // Redirect during a data miss is deferred
    dmem_req = 1'b1; redirect_req = 1'b1;
    repeat (2) begin settle(); chk("dwait_redir_defer", 64'(flush_id_ex), 64'h0); adv(); end
    dmem_resp = 1'b1;
    settle(); chk("dwait_redir_fire", 64'(flush_id_ex), 64'h1); adv();
    clear_in();

    // One-cycle redirect pulse while fetch outstanding must be remembered
    redirect_req = 1'b1; imem_read = 1'b1;
    step();
    redirect_req = 1'b0;
    repeat (2) begin settle(); chk("pend_hold", 64'(stall_ex), 64'h1); adv(); end
    imem_resp = 1'b1;
    settle(); chk("pend_fire", 64'(flush_if_id), 64'h1); adv();
    clear_in();

    // IFLUSH interrupted by a data miss, then resumed through IFLUSH
    redirect_req = 1'b1; imem_read = 1'b1;
    step();
    redirect_req = 1'b0; dmem_req = 1'b1;
    repeat (2) step();
    dmem_resp = 1'b1; step();
    dmem_req = 1'b0; dmem_resp = 1'b0;
    step();
    imem_resp = 1'b1; step();
    clear_in(); step();
    $display("phase redirect corner cases done");

    // Randomized traffic
    d_out = 1'b0; i_out = 1'b0;
    repeat (3000) begin
      if (!d_out) d_out = ($urandom_range(0, 7) == 0);
      dmem_req = d_out; dmem_resp = d_out && ($urandom_range(0, 2) == 0);
      if (!i_out) i_out = ($urandom_range(0, 3) == 0);
      imem_read = i_out; imem_resp = i_out && ($urandom_range(0, 2) == 0);
      redirect_req = ($urandom_range(0, 9) == 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1)); ex_load = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      mem_src = 3'($urandom_range(0, 4)); wb_src = 3'($urandom_range(0, 4));
      step();
      if (dmem_resp) d_out = 1'b0;
      if (imem_resp) i_out = 1'b0;
    end
    clear_in(); step(); step();
    $display("phase random done");

    // Saturation
    redirect_req = 1'b1;
    repeat (20) step();
    clear_in();
    settle(); chk("flush_sat", 64'(flush_count), 64'(FMAX)); adv();
    dmem_req = 1'b1;
    repeat (300) step();
    dmem_resp = 1'b1; step();
    clear_in();
    settle(); chk("stall_sat", 64'(stall_cycles), 64'(SMAX)); adv();
    $display("phase saturation done");

    // Asynchronous reset in the middle of IFLUSH
    redirect_req = 1'b1; imem_read = 1'b1;
    step(); step();
    #1;
    rst_n = 1'b0;
    #1;
    m_active = 1'b0; m_pend = 1'b0; m_stall = 0; m_flush = 0;
    chk("rst_async_ctl", 64'(obs_ctl()), 64'h0);
    chk("rst_async_cnt", 64'(flush_count), 64'h0);
    settle();
    adv();
    rst_n = 1'b1;
    clear_in();
    settle();
    adv();
    settle(); chk("rst_pend_dropped", 64'(obs_ctl()), 64'(11'b00000_000_1_00)); adv();
    $display("phase reset-mid-iflush done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
